// File: rtl/tl_adapter_pkg.sv
// Shared definitions for the TileLink-to-Vortex dcache lane adapter.
//   - TL-UL A/D channel opcode constants
//   - slot_state_e: lifecycle of one outstanding-load gather slot
//   - sat_add32: saturating 32-bit add used by the optional perf counters
//     (TL_DCACHE_ADAPTER_PERF_EN)
package tl_adapter_pkg;

  // A channel opcodes
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  // D channel opcodes
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    OPEN   = 2'd1,
    SEALED = 2'd2
  } slot_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/tl_rsp_gather_slot.sv
// One outstanding-load gather slot: tag, expected lanes, arrived lanes,
// per-lane data and a FREE -> OPEN -> SEALED -> FREE state.
// Ports:
//   clock, reset        clock / synchronous active-low reset
//   alloc, alloc_tag    claim this FREE slot for a new tag (clears contents)
//   add_lanes           load lanes that fired this cycle for this slot
//   seal                no further lanes will be added after this cycle
//   wr_lanes, wr_data   D beats routed to this slot (data per lane)
//   release_slot        gathered response accepted by the core
//   state, tag, expect_mask, arrived, data   current slot contents
module tl_rsp_gather_slot
  import tl_adapter_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alloc,
  input  logic [TAG_W-1:0]            alloc_tag,
  input  logic [NUM_LANES-1:0]        add_lanes,
  input  logic                        seal,
  input  logic [NUM_LANES-1:0]        wr_lanes,
  input  logic [NUM_LANES*DATA_W-1:0] wr_data,
  input  logic                        release_slot,
  output slot_state_e                 state,
  output logic [TAG_W-1:0]            tag,
  output logic [NUM_LANES-1:0]        expect_mask,
  output logic [NUM_LANES-1:0]        arrived,
  output logic [NUM_LANES*DATA_W-1:0] data
);

  slot_state_e                 state_q, state_d;
  logic [TAG_W-1:0]            tag_q;
  logic [NUM_LANES-1:0]        exp_q, arr_q;
  logic [NUM_LANES*DATA_W-1:0] data_q;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= FREE;
    else        state_q <= state_d;
  end

  // Next state; allocation and sealing may coincide
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FREE:    if (alloc)        state_d = seal ? SEALED : OPEN;
      OPEN:    if (seal)         state_d = SEALED;
      SEALED:  if (release_slot) state_d = FREE;
      default:                   state_d = FREE;
    endcase
  end

  // Outputs
  always_comb begin
    state       = state_q;
    tag         = tag_q;
    expect_mask = exp_q;
    arrived     = arr_q;
    data        = data_q;
  end

  // Contents; data is cleared on allocation so lanes outside the mask read 0
  always_ff @(posedge clock) begin
    if (!reset) begin
      tag_q  <= '0;
      exp_q  <= '0;
      arr_q  <= '0;
      data_q <= '0;
    end else if (alloc) begin
      tag_q  <= alloc_tag;
      exp_q  <= add_lanes;
      arr_q  <= '0;
      data_q <= '0;
    end else begin
      if (state_q == OPEN) exp_q <= exp_q | add_lanes;
      arr_q <= arr_q | wr_lanes;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (wr_lanes[i]) data_q[i*DATA_W +: DATA_W] <= wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/tl_dcache_lane_adapter.sv
// Splits an N-lane Vortex dcache request into N TL-UL A channels, gathers
// the per-lane AccessAckData beats per load tag and returns one registered
// Vortex response per tag. Store AccessAcks are absorbed.
// Ports:
//   clock, reset                      clock / synchronous active-low reset
//   core_req_*                        per-lane Vortex request, shared tag
//   core_rsp_*                        gathered response (valid/ready)
//   tl_a_*                            per-lane TL A channels
//   tl_d_*                            per-lane TL D channels (always ready)
//   err_sticky                        unmatched/duplicate/unexpected D beat
// Optional (`define TL_DCACHE_ADAPTER_PERF_EN):
//   perf_loads, perf_stores, perf_slot_stall   32-bit saturating counters
module tl_dcache_lane_adapter
  import tl_adapter_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 10,
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_LANES-1:0]                core_req_valid,
  input  logic [NUM_LANES-1:0]                core_req_rw,
  input  logic [NUM_LANES*DATA_W/8-1:0]       core_req_byteen,
  input  logic [NUM_LANES*(ADDR_W-2)-1:0]     core_req_addr,
  input  logic [NUM_LANES*DATA_W-1:0]         core_req_data,
  input  logic [TAG_W-1:0]                    core_req_tag,
  output logic [NUM_LANES-1:0]                core_req_ready,
  output logic                                core_rsp_valid,
  output logic [NUM_LANES-1:0]                core_rsp_tmask,
  output logic [NUM_LANES*DATA_W-1:0]         core_rsp_data,
  output logic [TAG_W-1:0]                    core_rsp_tag,
  input  logic                                core_rsp_ready,
  output logic [NUM_LANES-1:0]                tl_a_valid,
  input  logic [NUM_LANES-1:0]                tl_a_ready,
  output logic [3*NUM_LANES-1:0]              tl_a_opcode,
  output logic [4*NUM_LANES-1:0]              tl_a_size,
  output logic [TAG_W*NUM_LANES-1:0]          tl_a_source,
  output logic [ADDR_W*NUM_LANES-1:0]         tl_a_address,
  output logic [DATA_W/8*NUM_LANES-1:0]       tl_a_mask,
  output logic [DATA_W*NUM_LANES-1:0]         tl_a_data,
  input  logic [NUM_LANES-1:0]                tl_d_valid,
  output logic [NUM_LANES-1:0]                tl_d_ready,
  input  logic [3*NUM_LANES-1:0]              tl_d_opcode,
  input  logic [TAG_W*NUM_LANES-1:0]          tl_d_source,
  input  logic [DATA_W*NUM_LANES-1:0]         tl_d_data,
  output logic                                err_sticky
`ifdef TL_DCACHE_ADAPTER_PERF_EN
  ,
  output logic [31:0]                         perf_loads,
  output logic [31:0]                         perf_stores,
  output logic [31:0]                         perf_slot_stall
`endif
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned WA_W   = ADDR_W - 2;
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [3:0]  A_SIZE = 4'($clog2(DATA_W / 8));

  // Slot array views
  slot_state_e                 s_state [NUM_SLOTS];
  logic [TAG_W-1:0]            s_tag   [NUM_SLOTS];
  logic [NUM_LANES-1:0]        s_exp   [NUM_SLOTS];
  logic [NUM_LANES-1:0]        s_arr   [NUM_SLOTS];
  logic [NUM_LANES*DATA_W-1:0] s_data  [NUM_SLOTS];
  logic [NUM_LANES-1:0]        s_add   [NUM_SLOTS];
  logic [NUM_LANES-1:0]        s_wr    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]        s_alloc, s_seal, s_release, s_avail;

  // Request-side lookup
  logic              open_hit, any_open, free_exists, load_gate, new_alloc, all_fired;
  logic [SLOT_W-1:0] open_idx, old_open_idx, free_idx;
  logic [NUM_LANES-1:0] gate, fire, load_fire;

  // Response-side
  logic                        d_hit, err_d, load_en, sel_valid;
  logic [SLOT_W-1:0]           sel_idx, rr_ptr;
  logic [NUM_LANES*DATA_W-1:0] sel_data;

  logic                        rsp_valid_q;
  logic [NUM_LANES-1:0]        rsp_tmask_q;
  logic [NUM_LANES*DATA_W-1:0] rsp_data_q;
  logic [TAG_W-1:0]            rsp_tag_q;
  logic [SLOT_W-1:0]           rsp_slot_q;
  logic                        err_q;

  always_comb begin
    open_hit     = 1'b0;
    open_idx     = '0;
    any_open     = 1'b0;
    old_open_idx = '0;
    free_exists  = 1'b0;
    free_idx     = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (s_state[k] == OPEN) begin
        any_open     = 1'b1;
        old_open_idx = SLOT_W'(k);
        if (s_tag[k] == core_req_tag) begin
          open_hit = 1'b1;
          open_idx = SLOT_W'(k);
        end
      end
      if (s_state[k] == FREE && !free_exists) begin
        free_exists = 1'b1;
        free_idx    = SLOT_W'(k);
      end
    end
  end

  // Stores are never gated; loads need a matching OPEN slot or a FREE one.
  // Holding everything low while reset is asserted keeps the A side quiet.
  assign load_gate      = open_hit | free_exists;
  assign gate           = core_req_rw | {NUM_LANES{load_gate}};
  assign tl_a_valid     = core_req_valid & gate & {NUM_LANES{reset}};
  assign core_req_ready = tl_a_ready & gate & {NUM_LANES{reset}};
  assign fire           = tl_a_valid & tl_a_ready;
  assign load_fire      = fire & ~core_req_rw;
  assign new_alloc      = (|load_fire) && !open_hit;
  assign all_fired      = (|fire) && ((core_req_valid & ~fire) == '0);

  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!core_req_rw[i])                             tl_a_opcode[3*i +: 3] = GET;
      else if (core_req_byteen[BE_W*i +: BE_W] == '1)  tl_a_opcode[3*i +: 3] = PUT_FULL;
      else                                             tl_a_opcode[3*i +: 3] = PUT_PARTIAL;
      tl_a_address[ADDR_W*i +: ADDR_W] = {core_req_addr[WA_W*i +: WA_W], 2'b00};
    end
  end

  assign tl_a_size   = {NUM_LANES{A_SIZE}};
  assign tl_a_source = {NUM_LANES{core_req_tag}};
  assign tl_a_mask   = core_req_byteen;
  assign tl_a_data   = core_req_data;
  assign tl_d_ready  = '1;

  // Per-slot control. A new tag while another slot is OPEN seals that slot.
  always_comb begin
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      s_alloc[k] = new_alloc && (free_idx == SLOT_W'(k));
      s_add[k]   = (s_alloc[k] || (open_hit && open_idx == SLOT_W'(k))) ? load_fire : '0;
      s_seal[k]  = (all_fired && (s_alloc[k] || (open_hit && open_idx == SLOT_W'(k))))
                || (new_alloc && any_open && old_open_idx == SLOT_W'(k));
    end
  end

  // D routing: each AccessAckData beat goes to the first non-FREE slot with
  // that tag still waiting on the lane; no such slot is a protocol error.
  always_comb begin
    err_d = 1'b0;
    d_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) s_wr[k] = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      d_hit = 1'b0;
      if (tl_d_valid[i] && tl_d_opcode[3*i +: 3] == ACCESS_ACK_DATA) begin
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
          if (!d_hit && s_state[k] != FREE && s_tag[k] == tl_d_source[TAG_W*i +: TAG_W]
              && s_exp[k][i] && !s_arr[k][i]) begin
            d_hit      = 1'b1;
            s_wr[k][i] = 1'b1;
          end
        end
        if (!d_hit) err_d = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    tl_rsp_gather_slot #(
      .NUM_LANES (NUM_LANES),
      .DATA_W    (DATA_W),
      .TAG_W     (TAG_W)
    ) u_slot (
      .clock        (clock),
      .reset        (reset),
      .alloc        (s_alloc[k]),
      .alloc_tag    (core_req_tag),
      .add_lanes    (s_add[k]),
      .seal         (s_seal[k]),
      .wr_lanes     (s_wr[k]),
      .wr_data      (tl_d_data),
      .release_slot (s_release[k]),
      .state        (s_state[k]),
      .tag          (s_tag[k]),
      .expect_mask  (s_exp[k]),
      .arrived      (s_arr[k]),
      .data         (s_data[k])
    );
  end

  // Completion looks through this cycle's D beats so the response register
  // can load on the same edge as the final beat. The slot currently held in
  // the response register stays SEALED until accepted and is excluded.
  always_comb begin
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      s_avail[k]   = (s_state[k] == SEALED) && ((s_arr[k] | s_wr[k]) == s_exp[k])
                  && !(rsp_valid_q && rsp_slot_q == SLOT_W'(k));
      s_release[k] = rsp_valid_q && core_rsp_ready && rsp_slot_q == SLOT_W'(k);
    end
  end

  assign load_en = !rsp_valid_q || core_rsp_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = rr_ptr;
    for (int unsigned off = 0; off < NUM_SLOTS; off++) begin
      if (!sel_valid && s_avail[rr_ptr + SLOT_W'(off)]) begin
        sel_valid = 1'b1;
        sel_idx   = rr_ptr + SLOT_W'(off);
      end
    end
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      sel_data[DATA_W*i +: DATA_W] = s_wr[sel_idx][i] ? tl_d_data[DATA_W*i +: DATA_W]
                                                      : s_data[sel_idx][DATA_W*i +: DATA_W];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_tmask_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_slot_q  <= '0;
      rr_ptr      <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_q | err_d;
      if (load_en) begin
        rsp_valid_q <= sel_valid;
        if (sel_valid) begin
          rsp_tmask_q <= s_exp[sel_idx];
          rsp_data_q  <= sel_data;
          rsp_tag_q   <= s_tag[sel_idx];
          rsp_slot_q  <= sel_idx;
          rr_ptr      <= sel_idx + SLOT_W'(1);
        end
      end
    end
  end

  assign core_rsp_valid = rsp_valid_q;
  assign core_rsp_tmask = rsp_tmask_q;
  assign core_rsp_data  = rsp_data_q;
  assign core_rsp_tag   = rsp_tag_q;
  assign err_sticky     = err_q;

`ifdef TL_DCACHE_ADAPTER_PERF_EN
  logic [31:0] n_loads, n_stores;
  logic        stall_cycle;

  always_comb begin
    n_loads  = '0;
    n_stores = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      n_loads  = n_loads  + 32'(load_fire[i]);
      n_stores = n_stores + 32'(fire[i] & core_req_rw[i]);
    end
    // A ready load lane held back only because no slot can take its tag
    stall_cycle = (|(core_req_valid & ~core_req_rw & tl_a_ready)) && !load_gate;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_loads      <= '0;
      perf_stores     <= '0;
      perf_slot_stall <= '0;
    end else begin
      perf_loads      <= sat_add32(perf_loads, n_loads);
      perf_stores     <= sat_add32(perf_stores, n_stores);
      perf_slot_stall <= sat_add32(perf_slot_stall, 32'(stall_cycle));
    end
  end
`endif

endmodule
